// File: rtl/handshake_slice.sv
// handshake_slice: cascaded valid/ready register slices (MODE 0=FWD, 1=BWD, 2=FULL).
// Define HS_SLICE_BEAT_CNT_EN to add the beat_cnt delivered-beat counter port.
module handshake_slice #(
   parameter int DATA_WD = 8,
   parameter int MODE    = 2,
   parameter int STAGES  = 1,
   parameter int CNT_WD  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic [DATA_WD-1:0] data_in,
   output logic               ready_in,
   output logic               valid_out,
   output logic [DATA_WD-1:0] data_out,
`ifdef HS_SLICE_BEAT_CNT_EN
   output logic [CNT_WD-1:0]  beat_cnt,
`endif
   input  logic               ready_out
);
   if (MODE < 0 || MODE > 2 || STAGES < 1 || STAGES > 8 || DATA_WD < 1 || CNT_WD < 1) begin : g_bad
      $error("handshake_slice: illegal MODE/STAGES/DATA_WD/CNT_WD");
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic               vi, vo, ri, ro;
      logic [DATA_WD-1:0] di, dq;
      if (k == 0) begin : g_first
         assign vi = valid_in;
         assign di = data_in;
      end else begin : g_link
         assign vi = g_st[k-1].vo;
         assign di = g_st[k-1].dq;
      end
      if (k == STAGES - 1) begin : g_last
         assign ro = ready_out;
      end else begin : g_next
         assign ro = g_st[k+1].ri;
      end
      if (MODE == 0) begin : g_fwd
         logic               vr;
         logic [DATA_WD-1:0] dr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vr <= 1'b0;
               dr <= '0;
            end else if (ri) begin
               vr <= vi;
               if (vi) dr <= di;
            end
         end
         assign ri = ro || !vr;
         assign vo = vr;
         assign dq = dr;
      end else if (MODE == 1) begin : g_bwd
         logic               sv;
         logic [DATA_WD-1:0] sd;
         // skid only catches a beat that passed through while downstream stalled
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sv <= 1'b0;
               sd <= '0;
            end else if (sv) begin
               sv <= !ro;
            end else if (vi && !ro) begin
               sv <= 1'b1;
               sd <= di;
            end
         end
         assign ri = !sv;
         assign vo = vi || sv;
         assign dq = sv ? sd : di;
      end else begin : g_full
         localparam logic [1:0] S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2;
         logic [1:0]         st, st_nx;
         logic               rr, acc, out;
         logic [DATA_WD-1:0] md, sd;
         assign acc = vi && rr;
         assign out = (st != S_EMPTY) && ro;
         always_comb begin
            st_nx = st == S_EMPTY ? (acc ? S_ONE : S_EMPTY) :
                    st == S_ONE   ? (acc && !out ? S_TWO : (out && !acc ? S_EMPTY : S_ONE)) :
                                    (out ? S_ONE : S_TWO);
         end
         // ready is a register mirroring "next state is not full"
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               st <= S_EMPTY;
               rr <= 1'b1;
               md <= '0;
               sd <= '0;
            end else begin
               st <= st_nx;
               rr <= st_nx != S_TWO;
               if (st == S_TWO ? out : acc && (st == S_EMPTY || out)) md <= st == S_TWO ? sd : di;
               if (st == S_ONE && acc && !out) sd <= di;
            end
         end
         assign ri = rr;
         assign vo = st != S_EMPTY;
         assign dq = md;
      end
   end
   assign ready_in  = g_st[0].ri;
   assign valid_out = g_st[STAGES-1].vo;
   assign data_out  = g_st[STAGES-1].dq;
`ifdef HS_SLICE_BEAT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_cnt <= '0;
      else if (valid_out && ready_out) beat_cnt <= beat_cnt + CNT_WD'(1);
   end
`endif
endmodule
